// File: rtl/sap2_pkg.sv
// Shared SAP-II constants plus the program-counter command encoding.
// The decode helper gives the fixed priority of the controller strobes.
package sap2_pkg;

  localparam int          ADDR_W         = 16;
  localparam logic [15:0] ZERO_ADDR      = 16'h0000;
  localparam int          PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_JUMP,
    CMD_CALL,
    CMD_RET,
    CMD_CONFLICT
  } pc_cmd_e;

  // Strobes are active-low except cp; earlier tests win.
  function automatic pc_cmd_e decode_cmd(input logic cp, input logic nlp,
                                         input logic ncall, input logic nret);
    if (!ncall && !nret) return CMD_CONFLICT;
    if (!nret)           return CMD_RET;
    if (!ncall)          return CMD_CALL;
    if (!nlp)            return CMD_JUMP;
    if (cp)              return CMD_INC;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// DEPTH x WIDTH return-address LIFO. The caller guarantees no push when full
// and no pop when empty; the pointer has one spare bit so full != empty.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign wr_idx  = ptr_q[IDX_W-1:0];
  assign top_idx = ptr_q[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PTR_W'(DEPTH));

  always_comb begin
    ptr_d = ptr_q;
    if (push)     ptr_d = ptr_q + PTR_W'(1);
    else if (pop) ptr_d = ptr_q - PTR_W'(1);
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/program_counter.sv
// SAP-II program counter: PC register, prioritised command decode, return
// stack, sticky stack error, and the Ep-gated bus driver feeding mar.
module program_counter
  import sap2_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             Cp,
  input  logic             Ep,
  input  logic             nLp,
  input  logic             nCall,
  input  logic             nRet,
  input  logic [WIDTH-1:0] WBUS,
  output logic [WIDTH-1:0] pc_bus,
  output logic [WIDTH-1:0] PC,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [WIDTH-1:0] stk_top;
  pc_cmd_e          cmd;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .CLK   (CLK),
    .nCLR  (nCLR),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .top   (stk_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    cmd   = decode_cmd(Cp, nLp, nCall, nRet);
    case (cmd)
      CMD_CONFLICT: err_d = 1'b1;
      CMD_RET: begin
        if (stack_empty) err_d = 1'b1;
        else begin
          pop  = 1'b1;
          pc_d = stk_top;
        end
      end
      CMD_CALL: begin
        if (stack_full) err_d = 1'b1;
        else begin
          push = 1'b1;
          pc_d = WBUS;
        end
      end
      CMD_JUMP: pc_d = WBUS;
      CMD_INC:  pc_d = pc_q + WIDTH'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      pc_q  <= WIDTH'(ZERO_ADDR);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  // Bus is OR-combined upstream, so an idle driver must present zeros.
  assign pc_bus    = Ep ? pc_q : '0;
  assign PC        = pc_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: expected results are queued as each
// step is driven and popped for comparison after the sampling edge.
module tb_program_counter;

  logic        CLK = 1'b0;
  logic        nCLR = 1'b0;
  logic        Cp = 1'b0, Ep = 1'b0, nLp = 1'b1, nCall = 1'b1, nRet = 1'b1;
  logic [15:0] WBUS = 16'h0000;
  logic [15:0] pc_bus, PC;
  logic        stack_empty, stack_full, stack_err;

  logic        mar_nlw = 1'b1;
  logic [15:0] mar_q = 16'h0000;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] cur_pc = 16'h0000;

  program_counter dut (
    .CLK         (CLK),
    .nCLR        (nCLR),
    .Cp          (Cp),
    .Ep          (Ep),
    .nLp         (nLp),
    .nCall       (nCall),
    .nRet        (nRet),
    .WBUS        (WBUS),
    .pc_bus      (pc_bus),
    .PC          (PC),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 CLK = ~CLK;

  // Minimal mar stand-in for the fetch handshake.
  always @(posedge CLK) if (!mar_nlw) mar_q <= pc_bus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] pc, input logic e,
                           input logic f, input logic er);
    chk({tag, ".pc"}, 32'(PC), 32'(pc));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(e));
    chk({tag, ".full"}, 32'(stack_full), 32'(f));
    chk({tag, ".err"}, 32'(stack_err), 32'(er));
  endtask

  // Called at posedge+1; drives one cycle of commands and checks the result.
  task automatic step(input string tag, input logic cp, input logic ep, input logic nlp,
                      input logic ncall, input logic nret, input logic [15:0] wbus,
                      input logic [15:0] e_pc, input logic e_empty, input logic e_full,
                      input logic e_err);
    exp_t x;
    Cp = cp; Ep = ep; nLp = nlp; nCall = ncall; nRet = nret; WBUS = wbus;
    sb.push_back('{pc: e_pc, empty: e_empty, full: e_full, err: e_err, tag: tag});
    #1;
    chk({tag, ".bus"}, 32'(pc_bus), ep ? 32'(cur_pc) : 32'h0);
    @(posedge CLK);
    #1;
    Cp = 1'b0; Ep = 1'b0; nLp = 1'b1; nCall = 1'b1; nRet = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk_flags(x.tag, x.pc, x.empty, x.full, x.err);
    end
    cur_pc = e_pc;
  endtask

  // Mid-cycle asynchronous reset; checked before any further clock edge.
  task automatic async_reset(input string tag);
    nCLR = 1'b0;
    #2;
    chk_flags(tag, 16'h0000, 1'b1, 1'b0, 1'b0);
    nCLR = 1'b1;
    cur_pc = 16'h0000;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_flags("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("reset.bus", 32'(pc_bus), 32'h0);
    nCLR = 1'b1;

    //      tag       cp ep nlp ncall nret wbus      pc       e  f  er
    step("inc1",      1, 0, 1, 1, 1, 16'h0000, 16'h0001, 1, 0, 0);
    step("inc2",      1, 1, 1, 1, 1, 16'h0000, 16'h0002, 1, 0, 0);
    step("inc3",      1, 1, 1, 1, 1, 16'h0000, 16'h0003, 1, 0, 0);
    step("jmp_ffff",  0, 0, 0, 1, 1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    step("wrap",      1, 1, 1, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);
    step("jmp_pri",   1, 0, 0, 1, 1, 16'h1234, 16'h1234, 1, 0, 0);

    step("jmp_0010",  0, 0, 0, 1, 1, 16'h0010, 16'h0010, 1, 0, 0);
    step("call_2000", 1, 0, 0, 0, 1, 16'h2000, 16'h2000, 0, 0, 0);
    step("call_3000", 0, 0, 1, 0, 1, 16'h3000, 16'h3000, 0, 0, 0);
    step("ret_1",     1, 0, 0, 1, 0, 16'h5555, 16'h2000, 0, 0, 0);
    step("ret_2",     0, 1, 1, 1, 0, 16'h0000, 16'h0010, 1, 0, 0);

    step("ov_c1",     0, 0, 1, 0, 1, 16'h0100, 16'h0100, 0, 0, 0);
    step("ov_c2",     0, 0, 1, 0, 1, 16'h0200, 16'h0200, 0, 0, 0);
    step("ov_c3",     0, 0, 1, 0, 1, 16'h0300, 16'h0300, 0, 0, 0);
    step("ov_c4",     0, 0, 1, 0, 1, 16'h0400, 16'h0400, 0, 1, 0);
    step("ov_c5",     1, 0, 1, 0, 1, 16'h0500, 16'h0400, 0, 1, 1);
    step("ov_ret",    0, 0, 1, 1, 0, 16'h0000, 16'h0300, 0, 0, 1);
    step("err_stick", 1, 0, 1, 1, 1, 16'h0000, 16'h0301, 0, 0, 1);

    async_reset("arst1");
    step("underflow", 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 1);

    async_reset("arst2");
    step("cf_jmp",    0, 0, 0, 1, 1, 16'h0050, 16'h0050, 1, 0, 0);
    step("cf_call",   0, 0, 1, 0, 1, 16'h0060, 16'h0060, 0, 0, 0);
    step("conflict",  1, 0, 0, 0, 0, 16'h0777, 16'h0060, 0, 0, 1);
    step("cf_ret",    0, 0, 1, 1, 0, 16'h0000, 16'h0050, 1, 0, 1);

    async_reset("arst3");
    step("f_jmp",     0, 0, 0, 1, 1, 16'h0042, 16'h0042, 1, 0, 0);
    mar_nlw = 1'b0;
    step("fetch",     1, 1, 1, 1, 1, 16'h0000, 16'h0043, 1, 0, 0);
    mar_nlw = 1'b1;
    chk("fetch.mar", 32'(mar_q), 32'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

16-bit SAP-II program counter with a small hardware return-address stack. It sits directly upstream of `mar`. During the fetch cycle it drives the current instruction address onto the WBUS, and it advances, jumps, calls or returns under controller command. All state is registered. The bus output is combinational from the registered count, so `mar` captures the address on the same edge that the counter advances.

## Interface
- `WIDTH`, 16: address width, matches WBUS and `mar` address.
- `DEPTH`, 4: return-stack entries; must be a power of two, 2 to 16.
- `CLK` input 1: system clock, rising-edge active.
- `nCLR` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `Cp` input 1: increment PC (1 = increment).
- `Ep` input 1: drive PC onto `pc_bus` (1 = drive).
- `nLp` input 1: load PC from `WBUS` (jump; 0 = load).
- `nCall` input 1: push PC onto stack, load PC from `WBUS` (0 = call).
- `nRet` input 1: pop stack top into PC (0 = return).
- `WBUS` input WIDTH: jump/call target from the W bus.
- `pc_bus` output WIDTH: equals `PC` when `Ep`=1, otherwise all zeros (bus OR-combined at top level).
- `PC` output WIDTH: registered current count.
- `stack_empty` output 1: stack holds 0 entries.
- `stack_full` output 1: stack holds DEPTH entries.
- `stack_err` output 1: sticky overflow/underflow/conflict flag.

## Operation
- While `nCLR`=0:
  - `PC`=0x0000 and stack pointer=0.
  - `stack_empty`=1, `stack_full`=0, `stack_err`=0.
  - Stack contents are don't-care.
- Priority per rising edge, highest first:
  1. Conflict: `nCall`=0 and `nRet`=0 together. No change to PC or stack. `stack_err`<=1.
  2. Return: `nRet`=0.
     - Not empty: PC<=stack top, pointer−1.
     - Empty: PC unchanged, `stack_err`<=1.
  3. Call: `nCall`=0.
     - Not full: stack[pointer]<=PC, pointer+1, PC<=WBUS.
     - Full: nothing pushed, PC unchanged, `stack_err`<=1.
  4. Jump: `nLp`=0. PC<=WBUS.
  5. Increment: `Cp`=1. PC<=PC+1 modulo 2^WIDTH (0xFFFF wraps to 0x0000, no flag).
  6. Otherwise PC holds.
- A lower-priority command asserted with a higher one is ignored that cycle. For example, `Cp` together with `nLp` gives a jump only.
- The value pushed is the current PC, not PC+1. The controller increments past the CALL operand bytes before issuing `nCall`.
- `stack_err` clears only on `nCLR`.
- `stack_empty` and `stack_full` are decoded from the registered pointer. The pointer is log2(DEPTH)+1 bits so the full condition is distinguishable from empty.
- `Ep` has no effect on state.

## Timing
- Every command takes effect at the rising edge where it is sampled. `PC` shows the new value after that edge, so latency is 1 cycle.
- `pc_bus` is valid combinationally within the same cycle that `Ep`=1.
- Fetch handshake with `mar`, in one cycle:
  - `Ep`=1 together with `mar` `nLw`=0 makes `mar` capture the current PC at the edge.
  - If `Cp`=1 in the same cycle, PC advances at that same edge, so address and increment overlap without a hazard.
- Stack flags update at the same edge as the push or pop.
- Reset asserted mid-operation, including during a call or return edge, forces the reset state immediately. Deassertion is expected to be synchronised at the top level. The first edge after release acts normally.

## Structure
- Shared package `sap2_pkg` holds:
  - `ADDR_W`=16.
  - `ZERO_ADDR`=16'h0000.
  - `PC_STACK_DEPTH`=4, used as the default for `DEPTH`.
- One sub-module, `pc_stack`:
  - DEPTH×WIDTH LIFO with push, pop, top, empty and full.
  - No error logic; the parent owns priority and `stack_err`.
- Top-level `program_counter` contains the PC register, command priority decode, the bus gate and the sticky error flag.

## Test plan
- Reset and increment: hold `nCLR`=0, release, then `Cp`=1 for 3 cycles. Expect `PC` 0000→0001→0002→0003. `pc_bus`=0000 while `Ep`=0, and equals `PC` while `Ep`=1.
- Wrap and priority:
  - `nLp`=0 with `WBUS`=FFFF, then `Cp`=1: `PC`=FFFF, then 0000, with `stack_err` still 0.
  - `nLp`=0 and `Cp`=1 together with `WBUS`=1234: `PC`=1234, not 1235.
- Call/return nesting: from `PC`=0010, call 2000, then call 3000, then return twice.
  - `PC` sequence: 2000, 3000, 2000, 0010.
  - `stack_empty` 1→0→0→0→1.
- Overflow and underflow:
  - Perform 4 calls to reach `stack_full`=1. A 5th call leaves PC and stack unchanged and sets `stack_err`=1.
  - After reset, a return on an empty stack sets `stack_err`=1 with `PC`=0000.
- Conflict and async reset:
  - `nCall`=0 and `nRet`=0 together: PC and pointer unchanged, `stack_err`=1.
  - Assert `nCLR` mid-cycle between edges: `PC`=0000 and the flags return to reset values immediately, without waiting for a clock edge.
- Fetch with `mar`: `Ep`=1, `Cp`=1 and `mar` `nLw`=0 at `PC`=0042. After the edge, `mar` address=0042 and `PC`=0043.
